regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (regwrite/wr/wd) among NREQ writeback requesters (ALU, load unit, ...).

---
 rtl/regfile_write_arbiter_pkg.sv | 24 ++
 rtl/regfile_write_arbiter_rr_picker.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds the FSM state encoding, default widths and the round-robin pointer advance.
package regfile_write_arbiter_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 16;
    localparam int NREG       = 4;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    // Winner drops to lowest priority: the next scan starts one past it.
    function automatic int next_rr(input int idx, input int nreq);
        if (idx + 1 >= nreq) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational round-robin picker: scans the request vector from rr_ptr upward
// with wrap and returns the first asserted requester as one-hot plus index.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx
);

    // Rotating priority scan.
    always_comb begin
        int   c;
        logic found;
        c          = 0;
        found      = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end else begin
                c = c;
            end
            if (!found && req[c]) begin
                found         = 1'b1;
                win_onehot[c] = 1'b1;
                win_idx       = IDX_W'(c);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single reg_file write port among NREQ writeback sources.
// Optional read-after-write stall detection is enabled with `define REGARB_HAZARD_EN.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        grant,
    output logic                   regwrite,
    output logic [ADDR_W-1:0]      wr,
    output logic [DATA_W-1:0]      wd,
    output logic                   busy,
    output logic [7:0]             wcount
`ifdef REGARB_HAZARD_EN
    ,
    input  logic [ADDR_W-1:0]      rr1,
    input  logic [ADDR_W-1:0]      rr2,
    output logic                   stall
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              busy_q, busy_d;
    logic [7:0]        wcount_q, wcount_d;
    logic [NREQ-1:0]   grant_s;
    logic [NREQ-1:0]   win_onehot_s;
    logic [IDX_W-1:0]  win_idx_s;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .win_onehot (win_onehot_s),
        .win_idx    (win_idx_s)
    );

    // Next-state and output-register computation for the IDLE/WRITE handshake.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        regwrite_d = 1'b0;
        wr_d       = wr_q;
        wd_d       = wd_q;
        busy_d     = 1'b0;
        wcount_d   = wcount_q;
        grant_s    = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_s    = win_onehot_s;
                    wr_d       = req_addr[win_idx_s*ADDR_W +: ADDR_W];
                    wd_d       = req_data[win_idx_s*DATA_W +: DATA_W];
                    // Register 0 is hard-wired zero: handshake completes, no write.
                    regwrite_d = (wr_d != ADDR_W'(ZERO_REG));
                    rr_ptr_d   = IDX_W'(next_rr(int'(win_idx_s), NREQ));
                    busy_d     = 1'b1;
                    state_d    = S_WRITE;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (regwrite_q) begin
                    wcount_d = wcount_q + 8'd1;
                end else begin
                    wcount_d = wcount_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides any in-flight write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            regwrite_q <= 1'b0;
            wr_q       <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b0;
            wcount_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            regwrite_q <= regwrite_d;
            wr_q       <= wr_d;
            wd_q       <= wd_d;
            busy_q     <= busy_d;
            wcount_q   <= wcount_d;
        end
    end

    assign grant    = reset ? '0 : grant_s;
    assign regwrite = regwrite_q;
    assign wr       = wr_q;
    assign wd       = wd_q;
    assign busy     = busy_q;
    assign wcount   = wcount_q;

`ifdef REGARB_HAZARD_EN
    assign stall = (state_q == S_WRITE) && regwrite_q && (wr_q != ADDR_W'(ZERO_REG))
                   && ((rr1 == wr_q) || (rr2 == wr_q));
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NREQ=2, ADDR_W=2, DATA_W=16).
// Define REGARB_HAZARD_EN to also exercise the stall output.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [3:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  grant;
    logic        regwrite;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        busy;
    logic [7:0]  wcount;
`ifdef REGARB_HAZARD_EN
    logic [1:0]  rr1;
    logic [1:0]  rr2;
    logic        stall;
`endif

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(
        .NREQ   (2),
        .ADDR_W (2),
        .DATA_W (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .grant    (grant),
        .regwrite (regwrite),
        .wr       (wr),
        .wd       (wd),
        .busy     (busy),
        .wcount   (wcount)
`ifdef REGARB_HAZARD_EN
        ,
        .rr1      (rr1),
        .rr2      (rr2),
        .stall    (stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [1:0] exp_grant [3];
    logic [1:0] exp_addr  [3];
    logic [15:0] exp_data [3];

    initial begin
        reset    = 1'b1;
        req      = 2'b00;
        req_addr = 4'h0;
        req_data = 32'h0;
`ifdef REGARB_HAZARD_EN
        rr1 = 2'd0;
        rr2 = 2'd0;
`endif
        // 1. reset for two cycles
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_regwrite", 32'(regwrite), 32'h0);
        check("rst_wr", 32'(wr), 32'h0);
        check("rst_wd", 32'(wd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wcount", 32'(wcount), 32'h0);
        reset = 1'b0;
        tick();
        check("idle_regwrite", 32'(regwrite), 32'h0);

        // 2. single write from requester 0
        req      = 2'b01;
        req_addr = {2'd0, 2'd2};
        req_data = {16'h0000, 16'hA5A5};
        #1;
        check("s2_grant", 32'(grant), 32'h1);
        tick();
        req = 2'b00;
        #1;
        check("s2_grant_write", 32'(grant), 32'h0);
        check("s2_regwrite", 32'(regwrite), 32'h1);
        check("s2_wr", 32'(wr), 32'h2);
        check("s2_wd", 32'(wd), 32'hA5A5);
        check("s2_busy", 32'(busy), 32'h1);
        tick();
        check("s2_regwrite_off", 32'(regwrite), 32'h0);
        check("s2_busy_off", 32'(busy), 32'h0);
        check("s2_wcount", 32'(wcount), 32'h1);
        check("s2_wr_hold", 32'(wr), 32'h2);

        // 3. both requesting; pointer is at 1 after scenario 2
        req      = 2'b11;
        req_addr = {2'd3, 2'd1};
        req_data = {16'h3333, 16'h1111};
        exp_grant[0] = 2'b10; exp_addr[0] = 2'd3; exp_data[0] = 16'h3333;
        exp_grant[1] = 2'b01; exp_addr[1] = 2'd1; exp_data[1] = 16'h1111;
        exp_grant[2] = 2'b10; exp_addr[2] = 2'd3; exp_data[2] = 16'h3333;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("s3_grant%0d", i), 32'(grant), 32'(exp_grant[i]));
            tick();
            check($sformatf("s3_nogrant%0d", i), 32'(grant), 32'h0);
            check($sformatf("s3_regwrite%0d", i), 32'(regwrite), 32'h1);
            check($sformatf("s3_wr%0d", i), 32'(wr), 32'(exp_addr[i]));
            check($sformatf("s3_wd%0d", i), 32'(wd), 32'(exp_data[i]));
`ifdef REGARB_HAZARD_EN
            rr1 = exp_addr[i];
            rr2 = 2'd0;
            #1;
            check($sformatf("s6_stall_hit%0d", i), 32'(stall), 32'h1);
            rr1 = (exp_addr[i] == 2'd1) ? 2'd2 : 2'd1;
            rr2 = rr1;
            #1;
            check($sformatf("s6_stall_miss%0d", i), 32'(stall), 32'h0);
            rr1 = 2'd0;
            rr2 = 2'd0;
`endif
            if (i == 2) begin
                req = 2'b00;
            end
            tick();
        end
        check("s3_wcount", 32'(wcount), 32'h4);

        // 4. write to register 0: granted, never committed
        req      = 2'b01;
        req_addr = {2'd1, 2'd0};
        req_data = {16'h0000, 16'hFFFF};
        #1;
        check("s4_grant", 32'(grant), 32'h1);
        tick();
        req = 2'b00;
        #1;
        check("s4_regwrite", 32'(regwrite), 32'h0);
        check("s4_busy", 32'(busy), 32'h1);
        check("s4_wd", 32'(wd), 32'hFFFF);
`ifdef REGARB_HAZARD_EN
        check("s6_stall_zero", 32'(stall), 32'h0);
`endif
        tick();
        check("s4_wcount", 32'(wcount), 32'h4);

        // 5. pointer now 1, only req0 active: wrap-around grant, then reset in WRITE
        req      = 2'b01;
        req_addr = {2'd0, 2'd2};
        req_data = {16'h0000, 16'hA5A5};
        #1;
        check("s5_grant_wrap", 32'(grant), 32'h1);
        tick();
        check("s5_regwrite", 32'(regwrite), 32'h1);
        reset = 1'b1;
        #1;
        check("s5_grant_rst", 32'(grant), 32'h0);
        tick();
        check("s5_regwrite_rst", 32'(regwrite), 32'h0);
        check("s5_busy_rst", 32'(busy), 32'h0);
        check("s5_wcount_rst", 32'(wcount), 32'h0);
        check("s5_grant_in_rst", 32'(grant), 32'h0);
        reset    = 1'b0;
        req      = 2'b11;
        req_addr = {2'd3, 2'd1};
        req_data = {16'h3333, 16'h1111};
        #1;
        check("s5_ptr_zero", 32'(grant), 32'h1);
        tick();
        req = 2'b00;
        tick();
        check("s5_wcount_after", 32'(wcount), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
